// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode dispatch, optional load/store, writeback.
// A watchdog bounds every handshake wait; halt and error are terminal until reset.
module core_sequencer #(
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        if_req_valid,
   input  logic        if_req_ready,
   input  logic        if_rsp_valid,
   input  logic [31:0] if_rsp_inst,
   output logic [31:0] inst,
   input  logic        dec_is_load,
   input  logic        dec_is_store,
   input  logic        dec_wb,
   input  logic        dec_is_ebreak,
   output logic        ls_req_valid,
   input  logic        ls_req_ready,
   input  logic        ls_rsp_valid,
   output logic        rf_wen,
   output logic        pc_wen,
   output logic        halted,
   output logic        err,
   output logic [31:0] instret
);

   typedef enum logic [3:0] {
      S_IDLE, S_IF_REQ, S_IF_WAIT, S_EX, S_LS_REQ, S_LS_WAIT, S_WB, S_HALT, S_ERR
   } state_t;

   // Expiry fires on the cycle whose increment would bring the count to all-ones.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

   state_t               state_q, state_d;
   logic [TIMEOUT_W-1:0] wd_q;
   logic [31:0]          inst_q;
   logic [31:0]          instret_q;
   logic                 wd_active;
   logic                 wd_expire;

   assign wd_active = (state_q == S_IF_REQ)  || (state_q == S_IF_WAIT) ||
                      (state_q == S_LS_REQ)  || (state_q == S_LS_WAIT);
   assign wd_expire = wd_active && (wd_q == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wd_q      <= '0;
         inst_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            wd_q <= '0;
         else if (wd_active)
            wd_q <= wd_q + TIMEOUT_W'(1);
         if (state_q == S_IF_WAIT && if_rsp_valid)
            inst_q <= if_rsp_inst;
         if (state_q == S_WB)
            instret_q <= instret_q + 32'd1;
      end
   end

   // Handshake completion is tested before expiry so a late accept still wins.
   always_comb begin
      state_d      = state_q;
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      rf_wen       = 1'b0;
      pc_wen       = 1'b0;
      halted       = 1'b0;
      err          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start)
               state_d = S_IF_REQ;
         end
         S_IF_REQ: begin
            if_req_valid = 1'b1;
            if (if_req_ready)
               state_d = S_IF_WAIT;
            else if (wd_expire)
               state_d = S_ERR;
         end
         S_IF_WAIT: begin
            if (if_rsp_valid)
               state_d = S_EX;
            else if (wd_expire)
               state_d = S_ERR;
         end
         S_EX: begin
            if (dec_is_load && dec_is_store)
               state_d = S_ERR;
            else if (dec_is_ebreak)
               state_d = S_HALT;
            else if (dec_is_load || dec_is_store)
               state_d = S_LS_REQ;
            else
               state_d = S_WB;
         end
         S_LS_REQ: begin
            ls_req_valid = 1'b1;
            if (ls_req_ready)
               state_d = S_LS_WAIT;
            else if (wd_expire)
               state_d = S_ERR;
         end
         S_LS_WAIT: begin
            if (ls_rsp_valid)
               state_d = S_WB;
            else if (wd_expire)
               state_d = S_ERR;
         end
         S_WB: begin
            pc_wen  = 1'b1;
            rf_wen  = dec_wb && !dec_is_store;
            state_d = S_IF_REQ;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign inst    = inst_q;
   assign instret = instret_q;

endmodule
